// File: rtl/axi_node_aw_w_scheduler.sv
// Round-robin AW arbiter with an in-order W router for N_MASTER requesters sharing one slave AW/W pair.
// AW is a zero-latency pass-through; optional AW stall counter is enabled by AXI_NODE_SCHED_STALL_CNT_EN.
module axi_node_aw_w_scheduler #(
    parameter int AUX_WIDTH  = 1,
    parameter int ID_WIDTH   = 1,
    parameter int W_WIDTH    = 32,
    parameter int N_MASTER   = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int SEL_W     = (N_MASTER > 1) ? $clog2(N_MASTER) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_MASTER*ID_WIDTH-1:0]  inp_aw_id_i,
    input  logic [N_MASTER*AUX_WIDTH-1:0] inp_aw_aux_i,
    input  logic [N_MASTER-1:0]           inp_aw_valid_i,
    output logic [N_MASTER-1:0]           inp_aw_ready_o,
    output logic [ID_WIDTH-1:0]           oup_aw_id_o,
    output logic [AUX_WIDTH-1:0]          oup_aw_aux_o,
    output logic                          oup_aw_valid_o,
    input  logic                          oup_aw_ready_i,
    input  logic [N_MASTER*W_WIDTH-1:0]   inp_w_data_i,
    input  logic [N_MASTER-1:0]           inp_w_last_i,
    input  logic [N_MASTER-1:0]           inp_w_valid_i,
    output logic [N_MASTER-1:0]           inp_w_ready_o,
    output logic [W_WIDTH-1:0]            oup_w_data_o,
    output logic                          oup_w_last_o,
    output logic                          oup_w_valid_o,
    input  logic                          oup_w_ready_i,
    output logic [CNT_W-1:0]              outstanding_o,
    output logic [15:0]                   stall_cnt_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_ARB,
        ST_LOCK
    } state_t;

    state_t state_q, state_d;

    logic [ID_WIDTH-1:0]  aw_id  [N_MASTER];
    logic [AUX_WIDTH-1:0] aw_aux [N_MASTER];
    logic [W_WIDTH-1:0]   w_data [N_MASTER];

    for (genvar g = 0; g < N_MASTER; g++) begin : g_unpack
        assign aw_id[g]  = inp_aw_id_i[g*ID_WIDTH +: ID_WIDTH];
        assign aw_aux[g] = inp_aw_aux_i[g*AUX_WIDTH +: AUX_WIDTH];
        assign w_data[g] = inp_w_data_i[g*W_WIDTH +: W_WIDTH];
    end

    logic [SEL_W-1:0] rr_q;
    logic [SEL_W-1:0] lock_sel_q;
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] cand;
    logic             found;
    int               idx;

    logic [SEL_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [SEL_W-1:0] head;
    logic             not_empty;
    logic             full;
    logic             any_vld;
    logic             aw_vld;
    logic             aw_hs;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin scan from rr_q; a stalled grant overrides the scan until it completes.
    always_comb begin
        win   = rr_q;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_MASTER) begin
                idx = idx - N_MASTER;
            end
            cand = SEL_W'(idx);
            if (!found && inp_aw_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (state_q == ST_LOCK) begin
            win = lock_sel_q;
        end
    end

    // Full uses the registered count, so a same-cycle pop never frees a slot early.
    assign full      = (count_q == DEPTH_C);
    assign not_empty = (count_q != '0);
    assign any_vld   = |inp_aw_valid_i;
    assign aw_vld    = any_vld && !full && !rst_i;
    assign aw_hs     = aw_vld && oup_aw_ready_i;

    assign oup_aw_valid_o = aw_vld;
    assign oup_aw_id_o    = aw_vld ? aw_id[win]  : '0;
    assign oup_aw_aux_o   = aw_vld ? aw_aux[win] : '0;

    always_comb begin
        inp_aw_ready_o = '0;
        if (aw_hs) begin
            inp_aw_ready_o[win] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:  if (aw_vld && !oup_aw_ready_i) state_d = ST_LOCK;
            ST_LOCK: if (aw_hs) state_d = ST_ARB;
            default: state_d = ST_ARB;
        endcase
    end

    // W side: only the master at the head of the grant FIFO may transfer.
    assign head = fifo_q[rd_ptr_q];

    always_comb begin
        inp_w_ready_o = '0;
        oup_w_valid_o = 1'b0;
        oup_w_data_o  = '0;
        oup_w_last_o  = 1'b0;
        if (not_empty) begin
            oup_w_valid_o       = inp_w_valid_i[head];
            oup_w_data_o        = w_data[head];
            oup_w_last_o        = inp_w_last_i[head];
            inp_w_ready_o[head] = oup_w_ready_i;
        end
    end

    assign pop = oup_w_valid_o && oup_w_ready_i && oup_w_last_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_ARB;
            rr_q       <= '0;
            lock_sel_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ARB && state_d == ST_LOCK) begin
                lock_sel_q <= win;
            end
            if (aw_hs) begin
                rr_q     <= (win == SEL_W'(N_MASTER - 1)) ? '0 : win + 1'b1;
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({aw_hs, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (aw_hs) begin
            fifo_q[wr_ptr_q] <= win;
        end
    end

    assign outstanding_o = count_q;

`ifdef AXI_NODE_SCHED_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (any_vld && (full || !oup_aw_ready_i) && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule
